ps2_host_tx: RTL

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the processor side to the keyboard over the same open-drain kclk/kdata lines the PS/2 receiver listens on. Handles clock inhibit, start/data/parity/stop framing on device-generated clock edges, ACK check, and timeouts. Sits beside the PS/2 receiver under the PS/2 system-bus controller. `busy_o` lets the controller discard receiver output while a transfer is in progress.

---
 rtl/ps2_pkg.sv | 19 +
 rtl/ps2_line_sync.sv | 66 ++++++
 rtl/ps2_host_tx.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 host transmitter.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        SEND,
        ACK,
        WAIT_IDLE
    } ps2_tx_state_t;

    localparam int unsigned PARITY_IDX = 8;
    localparam int unsigned STOP_IDX   = 9;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-flop synchronizer, optional stability filter and falling-edge pulse for one PS/2 line.
module ps2_line_sync #(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    logic [1:0] sync_q, sync_d;
    logic       fall_q, fall_d;

    // Shift the raw line into the synchronizer chain.
    always_comb sync_d = {sync_q[0], line_i};

    // Synchronizer and edge flops; idle lines are high, so reset to 1 to avoid a spurious edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= 2'b11;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            fall_q <= fall_d;
        end
    end

    generate
        if (FILTER_LEN == 0) begin : g_raw
            assign level_o = sync_q[1];
            assign fall_d  = sync_q[1] & ~sync_q[0];
        end else begin : g_filt
            localparam int unsigned CW = $clog2(FILTER_LEN + 1);
            logic [CW-1:0] cnt_q, cnt_d;
            logic          level_q, level_d;

            // Accept a new level only after it has been stable for FILTER_LEN cycles.
            always_comb begin
                cnt_d   = '0;
                level_d = level_q;
                if (sync_q[1] != level_q) begin
                    if (cnt_q == CW'(FILTER_LEN - 1)) level_d = sync_q[1];
                    else                              cnt_d   = cnt_q + CW'(1);
                end
            end

            // Filter state registers.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    cnt_q   <= '0;
                    level_q <= 1'b1;
                end else begin
                    cnt_q   <= cnt_d;
                    level_q <= level_d;
                end
            end

            assign level_o = level_q;
            assign fall_d  = level_q & ~level_d;
        end
    endgenerate

    assign fall_o = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 byte transmitter with inhibit, framing, ACK check and timeouts.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 150000,
    parameter int unsigned FILTER_LEN     = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    input  logic       kclk_i,
    input  logic       kdata_i,
    output logic       kclk_oe_o,
    output logic       kdata_oe_o
);

    localparam int unsigned MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    ps2_tx_state_t state_q, state_d;
    logic [7:0]    sh_q, sh_d;
    logic          par_q, par_d;
    logic [3:0]    n_q, n_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          kclk_oe_q, kclk_oe_d;
    logic          kdata_oe_q, kdata_oe_d;
    logic          kclk_lvl, kclk_fall;
    logic          kdata_lvl, kdata_fall_unused;
    logic          tmo;

    ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_kclk_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .line_i (kclk_i),
        .level_o(kclk_lvl),
        .fall_o (kclk_fall)
    );

    ps2_line_sync #(.FILTER_LEN(0)) u_kdata_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .line_i (kdata_i),
        .level_o(kdata_lvl),
        .fall_o (kdata_fall_unused)
    );

    // Next-state, line-drive and pulse logic; a timeout overrides whatever the state decided.
    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        par_d      = par_q;
        n_d        = n_q;
        cnt_d      = cnt_q;
        kclk_oe_d  = kclk_oe_q;
        kdata_oe_d = kdata_oe_q;
        done_o     = 1'b0;
        err_o      = 1'b0;
        tmo        = (state_q inside {SEND, ACK, WAIT_IDLE}) && (cnt_q == CW'(TIMEOUT_CYCLES));
        case (state_q)
            IDLE: begin
                kclk_oe_d  = 1'b0;
                kdata_oe_d = 1'b0;
                if (valid_i) begin
                    sh_d      = data_i;
                    par_d     = odd_parity(data_i);
                    n_d       = 4'd0;
                    cnt_d     = '0;
                    kclk_oe_d = 1'b1;
                    state_d   = INHIBIT;
                end
            end
            INHIBIT: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(INHIBIT_CYCLES - 1)) kdata_oe_d = 1'b1;
                if (cnt_q == CW'(INHIBIT_CYCLES)) begin
                    kclk_oe_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                cnt_d = cnt_q + CW'(1);
                if (kclk_fall) begin
                    cnt_d      = '0;
                    kdata_oe_d = (n_q < 4'(PARITY_IDX)) ? ~sh_q[0] : (n_q == 4'(PARITY_IDX)) ? ~par_q : 1'b0;
                    sh_d       = {1'b0, sh_q[7:1]};
                    n_d        = n_q + 4'd1;
                    state_d    = (n_q == 4'(STOP_IDX)) ? ACK : SEND;
                end
            end
            ACK: begin
                cnt_d = cnt_q + CW'(1);
                if (kclk_fall) begin
                    cnt_d   = '0;
                    err_o   = kdata_lvl;
                    state_d = kdata_lvl ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                cnt_d = cnt_q + CW'(1);
                if (kclk_lvl && kdata_lvl) begin
                    done_o  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (tmo) begin
            kclk_oe_d  = 1'b0;
            kdata_oe_d = 1'b0;
            done_o     = 1'b0;
            err_o      = 1'b1;
            state_d    = IDLE;
        end
    end

    // State and datapath registers; reset releases both lines at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            sh_q       <= '0;
            par_q      <= 1'b0;
            n_q        <= '0;
            cnt_q      <= '0;
            kclk_oe_q  <= 1'b0;
            kdata_oe_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            par_q      <= par_d;
            n_q        <= n_d;
            cnt_q      <= cnt_d;
            kclk_oe_q  <= kclk_oe_d;
            kdata_oe_q <= kdata_oe_d;
        end
    end

    assign ready_o    = (state_q == IDLE);
    assign busy_o     = (state_q != IDLE);
    assign kclk_oe_o  = kclk_oe_q;
    assign kdata_oe_o = kdata_oe_q;

endmodule
